page_step_sequencer: RTL and testbench

//  Sequences the 3-bit branch memory-page register (which steps by +1/-1 via its increment/decrement inputs).

---
 rtl/page_pkg.sv | 16 +
 rtl/page_delta.sv | 33 +++
 rtl/page_step_sequencer.sv | 106 ++++++++++
 tb/tb_page_step_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/page_pkg.sv
// Shared definitions for the branch memory-page step sequencer.
package page_pkg;

  localparam int PAGE_W = 3;
  localparam int PAGES  = 2 ** PAGE_W;
  localparam int HALF   = 2 ** (PAGE_W - 1);

  typedef logic [PAGE_W-1:0] page_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2
  } pseq_state_t;

endpackage

// File: rtl/page_delta.sv
// Shortest-path distance between the current page and a target page on the
// circular page space. A forward distance of exactly HALF steps up.
module page_delta
  import page_pkg::*;
(
  input  page_t i_cur,
  input  page_t i_target,
  output logic  o_dir_up,
  output page_t o_n
);

  page_t w_fwd;

  // Forward distance wraps naturally in PAGE_W-bit arithmetic.
  assign w_fwd = i_target - i_cur;

  // Pick the shorter direction; going down costs PAGES - fwd, i.e. -fwd mod PAGES.
  always_comb begin
    o_dir_up = 1'b1;
    o_n      = '0;
    if (w_fwd == '0) begin
      o_dir_up = 1'b1;
      o_n      = '0;
    end else if (int'(w_fwd) <= HALF) begin
      o_dir_up = 1'b1;
      o_n      = w_fwd;
    end else begin
      o_dir_up = 1'b0;
      o_n      = '0 - w_fwd;
    end
  end

endmodule

// File: rtl/page_step_sequencer.sv
// Converts far-branch page changes and sequential page rollovers into a
// train of single +1/-1 pulses to the page register, stalls fetch while the
// change is in flight, and checks the landing page afterwards.
module page_step_sequencer
  import page_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  br_req,
  input  page_t br_target_page,
  input  logic  pc_wrap,
  input  page_t cur_page,
  output logic  increment,
  output logic  decrement,
  output logic  stall,
  output logic  done,
  output logic  page_err
);

  pseq_state_t r_state;
  pseq_state_t w_next_state;
  page_t       r_remaining;
  page_t       r_target;
  logic        r_dir_up;

  logic        w_dir_up;
  page_t       w_n;

  page_delta u_page_delta (
    .i_cur    (cur_page),
    .i_target (br_target_page),
    .o_dir_up (w_dir_up),
    .o_n      (w_n)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Capture direction, step count and target on entry; count steps down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= '0;
      r_dir_up    <= 1'b0;
      r_target    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A branch redirects the PC, so a coincident rollover is dropped.
          if (br_req) begin
            r_target    <= br_target_page;
            r_dir_up    <= w_dir_up;
            r_remaining <= w_n;
          end else if (pc_wrap) begin
            r_target    <= cur_page + 1'b1;
            r_dir_up    <= 1'b1;
            r_remaining <= page_t'(1);
          end
        end
        STEP:    r_remaining <= r_remaining - 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and Moore output decode.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    increment    = 1'b0;
    decrement    = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    page_err     = 1'b0;
    case (r_state)
      IDLE: begin
        if (br_req) begin
          w_next_state = (w_n == '0) ? CHECK : STEP;
        end else if (pc_wrap) begin
          w_next_state = STEP;
        end
      end
      STEP: begin
        stall     = 1'b1;
        increment = r_dir_up;
        decrement = !r_dir_up;
        if (r_remaining == page_t'(1)) w_next_state = CHECK;
      end
      CHECK: begin
        stall        = 1'b1;
        done         = 1'b1;
        // cur_page is the page register's flop output, settled after the
        // final step edge; comparing it here costs no extra cycle.
        page_err     = (cur_page != r_target);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_page_step_sequencer.sv
// Self-checking bench: a behavioural page register closes the loop, the
// stimulus pushes hand-computed expectations, and a monitor pops them on done.
module tb_page_step_sequencer;
  import page_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  br_req;
  page_t br_target_page;
  logic  pc_wrap;
  page_t cur_page;
  logic  increment;
  logic  decrement;
  logic  stall;
  logic  done;
  logic  page_err;

  logic  load;
  page_t load_val;
  logic  inject_dec;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string name;
    int    n_inc;
    int    n_dec;
    int    n_stall;
    int    err;
    int    page;
  } exp_t;

  exp_t sb_q[$];

  int mon_inc   = 0;
  int mon_dec   = 0;
  int mon_stall = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  page_step_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .br_req         (br_req),
    .br_target_page (br_target_page),
    .pc_wrap        (pc_wrap),
    .cur_page       (cur_page),
    .increment      (increment),
    .decrement      (decrement),
    .stall          (stall),
    .done           (done),
    .page_err       (page_err)
  );

  // Page register model: resets to 0, preloadable, steps on pulses, plus an
  // optional injected stray decrement.
  always @(posedge clk) begin
    if (reset)     cur_page <= '0;
    else if (load) cur_page <= load_val;
    else           cur_page <= cur_page + page_t'(increment) - page_t'(decrement)
                               - page_t'(inject_dec);
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: per-cycle invariants, pulse/stall accumulation, scoreboard pop on done.
  always @(negedge clk) begin
    if (reset) begin
      mon_inc   = 0;
      mon_dec   = 0;
      mon_stall = 0;
    end else begin
      check("inc_dec_exclusive", int'(increment & decrement), 0);
      if (!stall) check("no_pulse_when_idle", int'(increment | decrement), 0);
      if (stall) check("req_outside_idle", int'(br_req | pc_wrap), 0);
      mon_inc   += int'(increment);
      mon_dec   += int'(decrement);
      mon_stall += int'(stall);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("done_expected", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_inc"},   mon_inc,        e.n_inc);
          check({e.name, "_dec"},   mon_dec,        e.n_dec);
          check({e.name, "_stall"}, mon_stall,      e.n_stall);
          check({e.name, "_err"},   int'(page_err), e.err);
          check({e.name, "_page"},  int'(cur_page), e.page);
        end
        mon_inc   = 0;
        mon_dec   = 0;
        mon_stall = 0;
        done_count++;
      end
    end
  end

  task automatic set_page(input page_t p);
    load     = 1'b1;
    load_val = p;
    @(posedge clk); #1;
    load     = 1'b0;
  endtask

  // Issue one request in the current cycle, optionally inject a stray
  // decrement in the first step cycle, then wait (bounded) for done.
  task automatic issue(input string name, input logic br, input page_t tgt,
                       input logic wrap, input logic inject,
                       input int e_inc, input int e_dec, input int e_stall,
                       input int e_err, input int e_page);
    exp_t e;
    int   start;
    e.name = name; e.n_inc = e_inc; e.n_dec = e_dec; e.n_stall = e_stall;
    e.err = e_err; e.page = e_page;
    sb_q.push_back(e);
    start          = done_count;
    br_req         = br;
    br_target_page = tgt;
    pc_wrap        = wrap;
    @(posedge clk); #1;
    br_req  = 1'b0;
    pc_wrap = 1'b0;
    if (inject) begin
      inject_dec = 1'b1;
      @(posedge clk); #1;
      inject_dec = 1'b0;
    end
    for (int i = 0; i < 20 && done_count == start; i++) begin
      @(posedge clk); #1;
    end
    if (done_count == start) check({name, "_timeout"}, done_count - start, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    br_req         = 1'b0;
    br_target_page = '0;
    pc_wrap        = 1'b0;
    load           = 1'b0;
    load_val       = '0;
    inject_dec     = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_increment", int'(increment), 0);
    check("rst_decrement", int'(decrement), 0);
    check("rst_stall",     int'(stall),     0);
    check("rst_done",      int'(done),      0);
    check("rst_page_err",  int'(page_err),  0);
    check("rst_state",     int'(dut.r_state), int'(IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a 4-step sequence aborts it.
    set_page(3'd0);
    br_req         = 1'b1;
    br_target_page = 3'd4;
    @(posedge clk); #1;
    br_req = 1'b0;
    check("abort_first_pulse", int'(increment), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_increment", int'(increment), 0);
    check("abort_stall",     int'(stall),     0);
    reset = 1'b0;
    begin
      int pulses = 0;
      repeat (3) begin
        @(posedge clk); #1;
        pulses += int'(increment | decrement | stall);
      end
      check("abort_quiet_after", pulses, 0);
    end

    //                 name        br    tgt  wrap inj  inc dec stall err page
    set_page(3'd1);
    issue("up2",       1'b1, 3'd3, 1'b0, 1'b0, 2, 0, 3, 0, 3);
    set_page(3'd1);
    issue("down3",     1'b1, 3'd6, 1'b0, 1'b0, 0, 3, 4, 0, 6);
    set_page(3'd2);
    issue("tie_up4",   1'b1, 3'd6, 1'b0, 1'b0, 4, 0, 5, 0, 6);
    set_page(3'd5);
    issue("same_page", 1'b1, 3'd5, 1'b0, 1'b0, 0, 0, 1, 0, 5);
    set_page(3'd7);
    issue("wrap_7_0",  1'b0, 3'd3, 1'b1, 1'b0, 1, 0, 2, 0, 0);
    set_page(3'd0);
    issue("br_wins",   1'b1, 3'd4, 1'b1, 1'b0, 4, 0, 5, 0, 4);
    set_page(3'd0);
    issue("down_0_7",  1'b1, 3'd7, 1'b0, 1'b0, 0, 1, 2, 0, 7);
    set_page(3'd7);
    issue("br_7_0",    1'b1, 3'd0, 1'b0, 1'b0, 1, 0, 2, 0, 0);
    set_page(3'd4);
    issue("wrap_mid",  1'b0, 3'd0, 1'b1, 1'b0, 1, 0, 2, 0, 5);
    set_page(3'd0);
    issue("injected",  1'b1, 3'd2, 1'b0, 1'b1, 2, 0, 3, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
